vector_lane_dispatcher: RTL

Parametrised successor to the execution unit's vector-arithmetic path. It accepts one decoded vector arithmetic operation at a time and walks its elements in order. For each element it reads operands from the vector register file over two read ports, skips masked-off elements, and dispatches each active element to the lowest-numbered free functional lane. It supports vector-vector (VV) and vector-scalar (VS) modes, any lane count, and programmable length with a mask.

---
 rtl/vector_lane_dispatcher.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vector_lane_dispatcher.sv
// Walks one vector op element by element, fetches operands over two register-file read ports
// and issues each active element to the lowest free lane; 4 cycles per active element, stalls while all lanes are busy.
package vector_lane_dispatcher_pkg;
  typedef logic [3:0] function_opcode_t;
endpackage

module vector_lane_dispatcher
  import vector_lane_dispatcher_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VREGS  = 8,
  parameter int MAX_VLEN   = 64,
  localparam int VW = $clog2(NUM_VREGS),
  localparam int LW = $clog2(MAX_VLEN + 1),
  localparam int IW = $clog2(MAX_VLEN)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 op_vld,
  output logic                                 op_rdy,
  input  function_opcode_t                     op_func,
  input  logic                                 op_mode,
  input  logic [VW-1:0]                        op_src1,
  input  logic [VW-1:0]                        op_src2,
  input  logic [VW-1:0]                        op_dst,
  input  logic [DATA_WIDTH-1:0]                op_scalar,
  input  logic [LW-1:0]                        op_len,
  input  logic [MAX_VLEN-1:0]                  op_mask,
  output logic [1:0]                           rd_req,
  output logic [1:0][VW-1:0]                   rd_reg,
  output logic [1:0][IW-1:0]                   rd_idx,
  input  logic [1:0]                           rd_grant,
  input  logic [1:0]                           rd_rsp_vld,
  input  logic [1:0][DATA_WIDTH-1:0]           rd_rsp_data,
  input  logic [NUM_LANES-1:0]                 lane_busy,
  output logic [NUM_LANES-1:0]                 lane_vld,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data0,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data1,
  output function_opcode_t [NUM_LANES-1:0]     lane_func,
  output logic [NUM_LANES-1:0][VW-1:0]         lane_dst,
  output logic [NUM_LANES-1:0][IW-1:0]         lane_idx,
  output logic                                 busy,
  output logic                                 done
);

  localparam int LANEW = $clog2(NUM_LANES);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, DISPATCH} state_t;
  state_t state, state_n;

  function_opcode_t      func_q;
  logic                  mode_q;
  logic [VW-1:0]         src1_q, src2_q, dst_q;
  logic [DATA_WIDTH-1:0] scalar_q, opnd0_q, opnd1_q;
  logic [LW-1:0]         len_q, idx_q, len_clamped;
  logic [MAX_VLEN-1:0]   mask_q;
  logic [1:0]            held_q, held_n, needed, rsp_take, req_left;
  logic                  rsp_window, all_held, active_elem, at_end;
  logic [LANEW-1:0]      lane_sel;
  logic                  lane_free;

  assign len_clamped = (op_len > LW'(MAX_VLEN)) ? LW'(MAX_VLEN) : op_len;
  assign needed      = {~mode_q, 1'b1};
  assign rsp_window  = (state == REQ) || (state == WAIT);
  // A port's operand is taken once; a late duplicate cannot overwrite it.
  assign rsp_take    = rd_rsp_vld & needed & ~held_q & {2{rsp_window}};
  assign held_n      = held_q | rsp_take;
  assign all_held    = &(held_n | ~needed);
  assign req_left    = rd_req & ~rd_grant;
  assign at_end      = (idx_q == len_q);
  assign active_elem = mask_q[idx_q[IW-1:0]];

  always_comb begin
    lane_sel  = '0;
    lane_free = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!lane_busy[i]) begin
        lane_sel  = LANEW'(i);
        lane_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (op_vld && len_clamped != '0) state_n = SCAN;
      SCAN:     if (at_end) state_n = IDLE;
                else if (active_elem) state_n = REQ;
      REQ:      if (req_left == '0) state_n = WAIT;
      WAIT:     if (all_held) state_n = DISPATCH;
      DISPATCH: if (lane_free) state_n = SCAN;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_rdy     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_req     <= '0;
      rd_reg     <= '0;
      rd_idx     <= '0;
      lane_vld   <= '0;
      lane_data0 <= '0;
      lane_data1 <= '0;
      lane_func  <= '0;
      lane_dst   <= '0;
      lane_idx   <= '0;
      func_q     <= '0;
      mode_q     <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      scalar_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      held_q     <= '0;
      opnd0_q    <= '0;
      opnd1_q    <= '0;
    end else begin
      done     <= 1'b0;
      lane_vld <= '0;
      op_rdy   <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (op_vld) begin
            func_q   <= op_func;
            mode_q   <= op_mode;
            src1_q   <= op_src1;
            src2_q   <= op_src2;
            dst_q    <= op_dst;
            scalar_q <= op_scalar;
            len_q    <= len_clamped;
            mask_q   <= op_mask;
            idx_q    <= '0;
            held_q   <= '0;
            done     <= (len_clamped == '0);
          end
        end
        SCAN: begin
          if (at_end) begin
            done <= 1'b1;
          end else if (active_elem) begin
            rd_req <= {~mode_q, 1'b1};
            rd_reg <= {src2_q, src1_q};
            rd_idx <= {2{idx_q[IW-1:0]}};
            held_q <= '0;
          end else begin
            idx_q <= idx_q + LW'(1);
          end
        end
        REQ, WAIT: begin
          rd_req <= rd_req & ~rd_grant;
          held_q <= held_n;
          if (rsp_take[0]) opnd0_q <= rd_rsp_data[0];
          if (rsp_take[1]) opnd1_q <= rd_rsp_data[1];
        end
        DISPATCH: begin
          if (lane_free) begin
            lane_vld[lane_sel]   <= 1'b1;
            lane_data0[lane_sel] <= opnd0_q;
            lane_data1[lane_sel] <= mode_q ? scalar_q : opnd1_q;
            lane_func[lane_sel]  <= func_q;
            lane_dst[lane_sel]   <= dst_q;
            lane_idx[lane_sel]   <= idx_q[IW-1:0];
            idx_q                <= idx_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
